// File: rtl/data_memory_access_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_access_controller_pkg
// Purpose  : Shared types and constants for the data memory access controller:
//            sequencer state encoding, requester indices and default widths.
// Revision : 1.0 - initial release
// ============================================================================
package data_memory_access_controller_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Requester indices as carried by the arbiter grant index
    localparam logic REQ_R0 = 1'b0;
    localparam logic REQ_R1 = 1'b1;

    // Default geometry
    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_LAT    = 1;

endpackage : data_memory_access_controller_pkg
`default_nettype wire

// File: rtl/dm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_rr_arbiter
// Purpose  : Two-way round-robin arbiter. The grant is combinational on the
//            request lines; a registered last-grant pointer decides ties and
//            only moves when the controller strobes update.
// Revision : 1.0 - initial release
// ============================================================================
module dm_rr_arbiter
    import data_memory_access_controller_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic update,
    output logic grant_valid,
    output logic grant_idx
);

    logic r_last;

    // Tie goes to whoever was not granted last; a lone request always wins
    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_idx = (r_last == REQ_R0) ? REQ_R1 : REQ_R0;
        end else if (req1) begin
            grant_idx = REQ_R1;
        end else begin
            grant_idx = REQ_R0;
        end
    end

    // Remember the last winner; reset value makes R0 win the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= REQ_R1;
        end else if (update && grant_valid) begin
            r_last <= grant_idx;
        end
    end

endmodule : dm_rr_arbiter
`default_nettype wire

// File: rtl/data_memory_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_access_controller
// Purpose  : Shares a single-port synchronous data memory between two
//            requesters. Computes base+offset (wrapping), arbitrates
//            round-robin, issues one access, waits the read latency and
//            returns data with a one-cycle done pulse. All outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_access_controller
    import data_memory_access_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_LAT    = DEF_MEM_LAT
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] base0,
    input  logic [ADDR_WIDTH-1:0] base1,
    input  logic [ADDR_WIDTH-1:0] offset0,
    input  logic [ADDR_WIDTH-1:0] offset1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    // Counter holds MEM_LAT-1; keep at least one bit for MEM_LAT == 1
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t             r_state;
    logic               r_idx;
    logic               r_we;
    logic [CNT_W-1:0]   r_cnt;

    logic                  w_grant_valid;
    logic                  w_grant_idx;
    logic                  w_update;
    logic [ADDR_WIDTH-1:0] w_addr0;
    logic [ADDR_WIDTH-1:0] w_addr1;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_sel_we;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    // Effective addresses wrap modulo 2^ADDR_WIDTH; the carry is dropped
    assign w_addr0 = base0 + offset0;
    assign w_addr1 = base1 + offset1;

    // Operands of the requester the arbiter currently favours
    assign w_sel_addr  = (w_grant_idx == REQ_R1) ? w_addr1 : w_addr0;
    assign w_sel_we    = (w_grant_idx == REQ_R1) ? we1     : we0;
    assign w_sel_wdata = (w_grant_idx == REQ_R1) ? wdata1  : wdata0;

    // Requests are only looked at in IDLE, so the pointer moves only there
    assign w_update = (r_state == ST_IDLE);

    dm_rr_arbiter u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (req0),
        .req1        (req1),
        .update      (w_update),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // Access sequencer: IDLE -> ISSUE -> (write) IDLE | (read) WAIT -> IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= REQ_R0;
            r_we      <= 1'b0;
            r_cnt     <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_state   <= ST_ISSUE;
                        r_idx     <= w_grant_idx;
                        r_we      <= w_sel_we;
                        busy      <= 1'b1;
                        gnt0      <= (w_grant_idx == REQ_R0);
                        gnt1      <= (w_grant_idx == REQ_R1);
                        mem_en    <= 1'b1;
                        mem_we    <= w_sel_we;
                        mem_addr  <= w_sel_addr;
                        mem_wdata <= w_sel_we ? w_sel_wdata : '0;
                    end
                end
                ST_ISSUE: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    if (r_we) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                        done0   <= (r_idx == REQ_R0);
                        done1   <= (r_idx == REQ_R1);
                    end else begin
                        r_cnt   <= CNT_W'(MEM_LAT - 1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_idx == REQ_R0) begin
                            rdata0 <= mem_rdata;
                        end else begin
                            rdata1 <= mem_rdata;
                        end
                        done0   <= (r_idx == REQ_R0);
                        done1   <= (r_idx == REQ_R1);
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    busy      <= 1'b0;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
            endcase
        end
    end

endmodule : data_memory_access_controller
`default_nettype wire

// File: tb/tb_data_memory_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_access_controller
// Purpose  : Self-checking bench. A transaction-level model predicts every
//            output per cycle for the MEM_LAT=1 instance; directed tests add
//            hand-computed literal checks, and a MEM_LAT=3 instance checks
//            the longer read latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_access_controller;

    localparam int AW   = 11;
    localparam int DW   = 32;
    localparam int LAT  = 1;
    localparam int LATB = 3;
    localparam int NCYC = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    // main instance (MEM_LAT = 1)
    logic          req0, req1, we0, we1;
    logic [AW-1:0] base0, base1, offset0, offset1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1, mem_en, mem_we, busy;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    // second instance (MEM_LAT = 3)
    logic          req0_b, req1_b, we0_b, we1_b;
    logic [AW-1:0] base0_b, base1_b, offset0_b, offset1_b;
    logic [DW-1:0] wdata0_b, wdata1_b;
    logic          gnt0_b, gnt1_b, done0_b, done1_b, mem_en_b, mem_we_b, busy_b;
    logic [DW-1:0] rdata0_b, rdata1_b, mem_wdata_b, mem_rdata_b;
    logic [AW-1:0] mem_addr_b;

    data_memory_access_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .base0(base0), .base1(base1), .offset0(offset0), .offset1(offset1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    data_memory_access_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(LATB)) dut_b (
        .clk(clk), .rst_n(rst_n), .req0(req0_b), .req1(req1_b), .we0(we0_b), .we1(we1_b),
        .base0(base0_b), .base1(base1_b), .offset0(offset0_b), .offset1(offset1_b),
        .wdata0(wdata0_b), .wdata1(wdata1_b), .gnt0(gnt0_b), .gnt1(gnt1_b),
        .done0(done0_b), .done1(done1_b), .rdata0(rdata0_b), .rdata1(rdata1_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory stand-ins ----------------
    logic [DW-1:0] tb_mem [NCYC];
    logic [DW-1:0] pb1, pb2;

    initial begin
        mem_rdata = '0;
        mem_rdata_b = '0;
        pb1 = '0;
        pb2 = '0;
        forever begin
            @(posedge clk);
            if (mem_en && mem_we) tb_mem[mem_addr] <= mem_wdata;
            mem_rdata   <= (mem_en && !mem_we) ? tb_mem[mem_addr] : '0;
            pb1         <= (mem_en_b && !mem_we_b) ? (32'hC0DE0000 | {21'd0, mem_addr_b}) : '0;
            pb2         <= pb1;
            mem_rdata_b <= pb2;
        end
    end

    // ---------------- transaction-level model ----------------
    bit            e_gnt0 [NCYC];
    bit            e_gnt1 [NCYC];
    bit            e_done0[NCYC];
    bit            e_done1[NCYC];
    bit            e_en   [NCYC];
    bit            e_we   [NCYC];
    bit            e_busy [NCYC];
    bit [AW-1:0]   e_addr [NCYC];
    bit [DW-1:0]   e_wdata[NCYC];
    logic [DW-1:0] m_mem  [NCYC];
    int            m_free = 0;
    bit            m_last = 1'b1;
    logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
    bit            p_v = 1'b0;
    bit            p_who = 1'b0;
    int            p_c = 0;
    logic [DW-1:0] p_val = '0;

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            m_mem[i]  = 32'hA5A50000 | i;
            tb_mem[i] = 32'hA5A50000 | i;
        end
    end

    // One access per grant: write busy 1 cycle, done +2; read busy 1+LAT, done +2+LAT
    initial begin
        bit            w;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                for (int i = cyc; i < NCYC; i++) begin
                    e_gnt0[i] = 0; e_gnt1[i] = 0; e_done0[i] = 0; e_done1[i] = 0;
                    e_en[i] = 0; e_we[i] = 0; e_busy[i] = 0; e_addr[i] = 0; e_wdata[i] = 0;
                end
                m_free = cyc + 1;
                m_last = 1'b1;
                m_rd0  = '0;
                m_rd1  = '0;
                p_v    = 1'b0;
            end else if (cyc >= m_free && (req0 || req1)) begin
                w  = (req0 && req1) ? ~m_last : req1;
                m_last = w;
                a  = w ? (base1 + offset1) : (base0 + offset0);
                wr = w ? we1 : we0;
                d  = w ? wdata1 : wdata0;
                e_gnt0[cyc+1]  = !w;
                e_gnt1[cyc+1]  = w;
                e_en[cyc+1]    = 1;
                e_we[cyc+1]    = wr;
                e_addr[cyc+1]  = a;
                e_wdata[cyc+1] = wr ? d : '0;
                e_busy[cyc+1]  = 1;
                if (wr) begin
                    m_mem[a] = d;
                    if (w) e_done1[cyc+2] = 1; else e_done0[cyc+2] = 1;
                    m_free = cyc + 2;
                end else begin
                    for (int k = 1; k <= LAT; k++) e_busy[cyc+1+k] = 1;
                    if (w) e_done1[cyc+2+LAT] = 1; else e_done0[cyc+2+LAT] = 1;
                    p_v = 1'b1; p_who = w; p_c = cyc + 2 + LAT; p_val = m_mem[a];
                    m_free = cyc + 2 + LAT;
                end
            end
            cyc = cyc + 1;
            if (p_v && p_c == cyc) begin
                if (p_who) m_rd1 = p_val; else m_rd0 = p_val;
                p_v = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst gnt0", gnt0, 0);   chk("rst gnt1", gnt1, 0);
                chk("rst done0", done0, 0); chk("rst done1", done1, 0);
                chk("rst mem_en", mem_en, 0); chk("rst mem_we", mem_we, 0);
                chk("rst mem_addr", mem_addr, 0); chk("rst mem_wdata", mem_wdata, 0);
                chk("rst busy", busy, 0);
                chk("rst rdata0", rdata0, 0); chk("rst rdata1", rdata1, 0);
            end else begin
                chk("gnt0", gnt0, e_gnt0[cyc]);   chk("gnt1", gnt1, e_gnt1[cyc]);
                chk("done0", done0, e_done0[cyc]); chk("done1", done1, e_done1[cyc]);
                chk("mem_en", mem_en, e_en[cyc]); chk("mem_we", mem_we, e_we[cyc]);
                chk("mem_addr", mem_addr, e_addr[cyc]); chk("mem_wdata", mem_wdata, e_wdata[cyc]);
                chk("busy", busy, e_busy[cyc]);
                chk("rdata0", rdata0, m_rd0); chk("rdata1", rdata1, m_rd1);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int gq[$];
    int dq[$];

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        base0 = '0; base1 = '0; offset0 = '0; offset1 = '0; wdata0 = '0; wdata1 = '0;
        req0_b = 0; req1_b = 0; we0_b = 0; we1_b = 0;
        base0_b = '0; base1_b = '0; offset0_b = '0; offset1_b = '0; wdata0_b = '0; wdata1_b = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset rdata0", rdata0, 0);
        tick();
        rst_n = 1'b1;

        // single write R0: 0x010 + 0x005
        req0 = 1; we0 = 1; base0 = 11'h010; offset0 = 11'h005; wdata0 = 32'hDEADBEEF;
        tick(); req0 = 0;
        @(negedge clk);
        chk("wr gnt0", gnt0, 1); chk("wr mem_en", mem_en, 1); chk("wr mem_we", mem_we, 1);
        chk("wr mem_addr", mem_addr, 11'h015); chk("wr mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick(); @(negedge clk);
        chk("wr done0", done0, 1); chk("wr busy", busy, 0);

        // read R1 of 0x015, MEM_LAT=1 -> done in cycle 3
        tick();
        req1 = 1; we1 = 0; base1 = 11'h015; offset1 = 11'h000;
        tick(); req1 = 0;
        @(negedge clk);
        chk("rd gnt1", gnt1, 1); chk("rd mem_we", mem_we, 0); chk("rd mem_wdata", mem_wdata, 0);
        tick(); @(negedge clk);
        chk("rd done1 early", done1, 0); chk("rd busy wait", busy, 1);
        tick(); @(negedge clk);
        chk("rd done1", done1, 1); chk("rd rdata1", rdata1, 32'hDEADBEEF); chk("rd rdata0 kept", rdata0, 0);

        // read R1 on the MEM_LAT=3 instance -> done in cycle 5
        tick();
        req1_b = 1; we1_b = 0; base1_b = 11'h015; offset1_b = 11'h000;
        tick(); req1_b = 0;
        @(negedge clk);
        chk("lat3 gnt1", gnt1_b, 1);
        for (int k = 2; k <= 5; k++) begin
            tick(); @(negedge clk);
            chk("lat3 done1", done1_b, (k == 5) ? 1 : 0);
        end
        chk("lat3 rdata1", rdata1_b, 32'hC0DE0015);

        // R0 read of untouched location -> initial content
        tick();
        req0 = 1; we0 = 0; base0 = 11'h100; offset0 = 11'h023;
        tick(); req0 = 0;
        tick(); tick(); @(negedge clk);
        chk("rd0 done0", done0, 1); chk("rd0 rdata0", rdata0, 32'hA5A50123);
        chk("rd0 rdata1 kept", rdata1, 32'hDEADBEEF);

        // address wrap-around
        tick();
        req0 = 1; we0 = 1; base0 = 11'h7FF; offset0 = 11'h002; wdata0 = 32'h11111111;
        tick(); req0 = 0;
        @(negedge clk);
        chk("wrap1 mem_addr", mem_addr, 11'h001);
        tick(); tick();
        req1 = 1; we1 = 1; base1 = 11'h400; offset1 = 11'h400; wdata1 = 32'h22222222;
        tick(); req1 = 0;
        @(negedge clk);
        chk("wrap2 mem_addr", mem_addr, 11'h000);
        tick();

        // contention from reset: grants alternate R0,R1,R0,R1
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        req0 = 1; we0 = 1; base0 = 11'h020; offset0 = 11'h000; wdata0 = 32'hAAAA0000;
        req1 = 1; we1 = 1; base1 = 11'h030; offset1 = 11'h000; wdata1 = 32'hBBBB0000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) begin req0 = 0; req1 = 0; end
            @(negedge clk);
            if (gnt0) gq.push_back(0);
            if (gnt1) gq.push_back(1);
        end
        chk("cont grant count", gq.size(), 4);
        if (gq.size() == 4) begin
            chk("cont g0", gq[0], 0); chk("cont g1", gq[1], 1);
            chk("cont g2", gq[2], 0); chk("cont g3", gq[3], 1);
        end

        // reset during WAIT of a read: no done, outputs drop at once
        tick();
        req0 = 1; we0 = 0; base0 = 11'h015; offset0 = 11'h000;
        tick(); req0 = 0;
        tick(); rst_n = 1'b0;
        @(negedge clk);
        chk("midrst busy", busy, 0); chk("midrst done0", done0, 0);
        tick(); @(negedge clk);
        chk("midrst no done0", done0, 0);
        tick(); rst_n = 1'b1;
        req0 = 1; we0 = 1; base0 = 11'h050; offset0 = 11'h001; wdata0 = 32'h33333333;
        tick(); req0 = 0;
        @(negedge clk);
        chk("postrst gnt0", gnt0, 1); chk("postrst mem_addr", mem_addr, 11'h051);
        tick(); tick();

        // R1 streaming writes: GNT at 1,3,5,7 and DONE at 2,4,6,8
        req1 = 1; we1 = 1; base1 = 11'h060; offset1 = 11'h000; wdata1 = 32'h40000000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) req1 = 0;
            @(negedge clk);
            if (gnt1) begin gq.push_back(100 + k); wdata1 = wdata1 + 1; end
            if (done1) dq.push_back(k);
        end
        chk("stream count", gq.size(), 8);
        chk("stream done count", dq.size(), 4);
        if (gq.size() == 8 && dq.size() == 4) begin
            chk("stream g1", gq[4], 101); chk("stream g3", gq[5], 103);
            chk("stream g5", gq[6], 105); chk("stream g7", gq[7], 107);
            chk("stream d2", dq[0], 2); chk("stream d4", dq[1], 4);
            chk("stream d6", dq[2], 6); chk("stream d8", dq[3], 8);
        end

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_data_memory_access_controller
`default_nettype wire

// File: doc/data_memory_access_controller.md
Name: data_memory_access_controller

Overview:
Sequences every access to the single-port synchronous data memory and shares it between two requesters: R0 (load/store stage) and R1 (secondary master, e.g. I/O or debug loader). Each requester supplies a base and an offset. The block computes the effective address, arbitrates round-robin, drives the memory strobes, waits the fixed read latency, and returns read data with a one-cycle DONE pulse. It sits between the pipeline/masters and the data memory macro.

Parameters:
ADDR_WIDTH, 11, effective address, base and offset width
DATA_WIDTH, 32, memory word width
MEM_LAT, 1, read latency in cycles from the MEM_EN cycle to valid MEM_RDATA (legal values are 1 or more)

Ports:
CLK  in  1  system clock; all state updates on the rising edge
RST_N  in  1  asynchronous, active-low reset
REQ0 / REQ1  in  1  access request; held with operands stable until GNTx
WE0 / WE1  in  1  1 = write, 0 = read
BASE0 / BASE1  in  ADDR_WIDTH  base address
OFFSET0 / OFFSET1  in  ADDR_WIDTH  address offset
WDATA0 / WDATA1  in  DATA_WIDTH  write data
GNT0 / GNT1  out  1  one-cycle pulse: request accepted, operands latched
DONE0 / DONE1  out  1  one-cycle pulse: access complete
RDATA0 / RDATA1  out  DATA_WIDTH  read result; valid with DONEx and held until the next read completes for that requester
MEM_EN  out  1  memory access strobe
MEM_WE  out  1  memory write enable
MEM_ADDR  out  ADDR_WIDTH  effective address
MEM_WDATA  out  DATA_WIDTH  write data
MEM_RDATA  in  DATA_WIDTH  memory read data
BUSY  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered. While RST_N=0 every output is 0, the state is IDLE, and the round-robin pointer is set so that R0 wins the first tie.
- States: IDLE, ISSUE, WAIT.
- IDLE: if any REQ is high at the edge ending cycle t, arbitrate and latch the winner's WE, WDATA and address. Address = (BASE + OFFSET) mod 2^ADDR_WIDTH; carry is discarded, no error is raised. Next state is ISSUE.
- Arbitration:
  - Only one request: that requester wins.
  - Both requesting: the requester not granted last wins, then the pointer updates.
  - A requester is never granted twice in a row while the other is requesting.
- ISSUE (cycle t+1):
  - GNTx=1, MEM_EN=1, MEM_WE=latched WE, MEM_ADDR=latched address.
  - MEM_WDATA=latched data for a write, 0 for a read.
  - Write: next state IDLE, and DONEx=1 in cycle t+2.
  - Read: load a counter with MEM_LAT-1, next state WAIT.
- WAIT:
  - MEM_EN=0. Decrement the counter each cycle.
  - At the edge where the counter is 0 (end of cycle t+1+MEM_LAT), capture MEM_RDATA into RDATAx.
  - In cycle t+2+MEM_LAT: DONEx=1, state IDLE.
- Latency:
  - Write: GNT at +1, DONE at +2; maximum throughput is one write every 2 cycles.
  - Read: DONE at MEM_LAT+2.
- Outside ISSUE: MEM_EN=0, MEM_WE=0, MEM_ADDR and MEM_WDATA = 0.
- A REQ dropped before its grant is simply not served; there is no error.
- REQ is ignored in ISSUE and WAIT. A REQ still high in the IDLE cycle that carries DONE is arbitrated normally.
- RDATAx is unchanged by writes and by the other requester's reads.
- Reset mid-operation: all outputs drop to 0 immediately and asynchronously, the in-flight access is abandoned, and no DONE is produced.

Decomposition:
- Shared package: state encoding (IDLE/ISSUE/WAIT), requester index constants (REQ_R0, REQ_R1), default width constants.
- One sub-module: dm_rr_arbiter, a 2-way round-robin arbiter with a registered last-grant pointer. It is combinational on REQ and takes an update strobe from the FSM.

Test Plan:
- Single write, R0: BASE=0x010, OFFSET=0x005, WDATA=0xDEADBEEF, REQ0 at cycle 0 -> cycle 1: GNT0=1, MEM_EN=1, MEM_WE=1, MEM_ADDR=0x015, MEM_WDATA=0xDEADBEEF; cycle 2: DONE0=1, BUSY=0.
- Read, R1, MEM_LAT=1: BASE=0x015, OFFSET=0, memory returns 0xDEADBEEF -> cycle 1: GNT1, MEM_EN=1, MEM_WE=0; cycle 3: DONE1=1, RDATA1=0xDEADBEEF; RDATA0 unchanged. Repeat with MEM_LAT=3 -> DONE1 in cycle 5.
- Contention: REQ0 and REQ1 held high from reset with writes -> grants go R0, R1, R0, R1; each GNT is followed by its DONE; no back-to-back grant to one requester.
- Wrap-around: BASE=0x7FF, OFFSET=0x002 -> MEM_ADDR=0x001; BASE=0x400, OFFSET=0x400 -> MEM_ADDR=0x000.
- Reset mid-read: assert RST_N=0 during WAIT -> all outputs 0 in the same cycle, no DONE. After release, REQ0 then gets GNT0 one cycle later, as after power-up.
- Single-requester streaming: REQ1 held high for 4 writes, R0 idle -> GNT1 in cycles 1, 3, 5, 7 and DONE1 in cycles 2, 4, 6, 8.
